control_multicycle: RTL and testbench

Multi-cycle successor to the single-cycle control unit: a Moore-style FSM that sequences fetch, decode, execute, memory and writeback over several cycles so one ALU and one unified memory port are shared. Sits between the instruction register / datapath flags and the datapath mux selects and write enables. Adds memory-ready stalling, correct JAL PC update, illegal-opcode detection and selectable branch coverage.

---
 rtl/control_pkg.sv | 67 ++++++
 rtl/control_multicycle_if.sv | 34 +++
 rtl/control_alu_decoder.sv | 34 +++
 rtl/control_multicycle.sv | 183 ++++++++++++++++++
 tb/tb_control_multicycle.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: state codes, opcodes,
// ALU codes and datapath mux selects.
package control_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecR    = 4'd6;
  localparam state_t StExecI    = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StBranch   = 4'd9;
  localparam state_t StJal      = 4'd10;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResReadData  = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // State-decoded control bundle (everything except imm_src and alu_control).
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_multicycle_if.sv
// Datapath <-> control unit bundle. master = datapath side, slave = control unit.
interface control_multicycle_if #(
  parameter int unsigned INSTR_WIDTH = 32
);
  logic [INSTR_WIDTH-1:0] instr;
  logic                   zero;
  logic                   lt;
  logic                   ltu;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   ir_write;
  logic                   mem_write;
  logic                   reg_write;
  logic                   adr_src;
  logic [1:0]             alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             result_src;
  logic [1:0]             imm_src;
  logic [2:0]             alu_control;
  logic                   illegal_instr;
  logic [3:0]             state_o;

  modport master (
    output instr, zero, lt, ltu, mem_ready,
    input  pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, illegal_instr, state_o
  );

  modport slave (
    input  instr, zero, lt, ltu, mem_ready,
    output pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a, alu_src_b,
           result_src, imm_src, alu_control, illegal_instr, state_o
  );
endinterface

// File: rtl/control_alu_decoder.sv
// Combinational ALU decoder: alu_op plus funct fields -> alu_control.
module control_alu_decoder
  import control_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic       i_funct7_5,
  input  logic [2:0] i_funct3,
  input  logic [1:0] i_alu_op,
  output logic [2:0] o_alu_control
);

  // Only opcode[5] separates R-type (sub allowed) from I-type (addi only).
  logic w_unused;
  assign w_unused = ^{i_opcode[6], i_opcode[4:0]};

  // Select ALU operation from the FSM request and the instruction funct fields.
  always_comb begin
    o_alu_control = AluAdd;
    case (i_alu_op)
      AluOpSub:   o_alu_control = AluSub;
      AluOpFunct: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_funct7_5 && i_opcode[5]) ? AluSub : AluAdd;
          3'b010:  o_alu_control = AluSlt;
          3'b110:  o_alu_control = AluOr;
          3'b111:  o_alu_control = AluAnd;
          default: o_alu_control = AluAdd;
        endcase
      end
      default:    o_alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/control_multicycle.sv
// Multi-cycle Moore control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory-ready stalls and illegal-opcode detection.
// Optional feature macro: CONTROL_FULL_BRANCH_EN (adds blt/bge/bltu/bgeu).
module control_multicycle
  import control_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  control_multicycle_if.slave bus
);

  state_t     r_state;
  state_t     w_state_next;
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7_5;
  logic       w_op_legal;
  logic       w_br_legal;
  logic       w_br_taken;
  ctrl_t      w_ctrl;
  logic       w_unused;

  assign w_opcode   = bus.instr[6:0];
  assign w_funct3   = bus.instr[14:12];
  assign w_funct7_5 = bus.instr[30];

`ifdef CONTROL_FULL_BRANCH_EN
  assign w_unused = ^{bus.instr[INSTR_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7]};
`else
  assign w_unused = ^{bus.instr[INSTR_WIDTH-1:31], bus.instr[29:15], bus.instr[11:7],
                      bus.lt, bus.ltu};
`endif

  // Opcodes the FSM knows how to sequence.
  always_comb begin
    case (w_opcode)
      OpLoad, OpStore, OpRtype, OpItype, OpBranch, OpJal: w_op_legal = 1'b1;
      default:                                            w_op_legal = 1'b0;
    endcase
  end

  // Branch condition evaluation; unsupported funct3 is never taken.
  always_comb begin
    w_br_taken = 1'b0;
    w_br_legal = 1'b1;
    case (w_funct3)
      3'b000:  w_br_taken = bus.zero;
      3'b001:  w_br_taken = !bus.zero;
`ifdef CONTROL_FULL_BRANCH_EN
      3'b100:  w_br_taken = bus.lt;
      3'b101:  w_br_taken = !bus.lt;
      3'b110:  w_br_taken = bus.ltu;
      3'b111:  w_br_taken = !bus.ltu;
`endif
      default: w_br_legal = 1'b0;
    endcase
  end

  // Next-state selection.
  always_comb begin
    w_state_next = StFetch;
    case (r_state)
      StFetch:    w_state_next = bus.mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (w_opcode)
          OpLoad, OpStore: w_state_next = StMemAdr;
          OpRtype:         w_state_next = StExecR;
          OpItype:         w_state_next = StExecI;
          OpBranch:        w_state_next = StBranch;
          OpJal:           w_state_next = StJal;
          default:         w_state_next = StFetch;
        endcase
      end
      StMemAdr:   w_state_next = (w_opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  w_state_next = bus.mem_ready ? StMemWb : StMemRead;
      StMemWb:    w_state_next = StFetch;
      StMemWrite: w_state_next = bus.mem_ready ? StFetch : StMemWrite;
      StExecR:    w_state_next = StAluWb;
      StExecI:    w_state_next = StAluWb;
      StAluWb:    w_state_next = StFetch;
      StBranch:   w_state_next = StFetch;
      StJal:      w_state_next = StAluWb;
      default:    w_state_next = StFetch;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= StFetch;
    else        r_state <= w_state_next;
  end

  // Moore output decode; reset forces FETCH selects with all writes off.
  always_comb begin
    w_ctrl = '0;
    if (!rst_n) begin
      w_ctrl.alu_src_b  = SrcBFour;
      w_ctrl.result_src = ResAluResult;
    end else begin
      case (r_state)
        StFetch: begin
          w_ctrl.alu_src_b  = SrcBFour;
          w_ctrl.result_src = ResAluResult;
          w_ctrl.ir_write   = bus.mem_ready;
          w_ctrl.pc_write   = bus.mem_ready;
        end
        StDecode: begin
          w_ctrl.alu_src_a = SrcAOldPc;
          w_ctrl.alu_src_b = SrcBImm;
          w_ctrl.illegal   = !w_op_legal;
        end
        StMemAdr: begin
          w_ctrl.alu_src_a = SrcARs1;
          w_ctrl.alu_src_b = SrcBImm;
        end
        StMemRead:  w_ctrl.adr_src = 1'b1;
        StMemWb: begin
          w_ctrl.result_src = ResReadData;
          w_ctrl.reg_write  = 1'b1;
        end
        StMemWrite: begin
          w_ctrl.adr_src   = 1'b1;
          w_ctrl.mem_write = 1'b1;
        end
        StExecR: begin
          w_ctrl.alu_src_a = SrcARs1;
          w_ctrl.alu_src_b = SrcBRs2;
          w_ctrl.alu_op    = AluOpFunct;
        end
        StExecI: begin
          w_ctrl.alu_src_a = SrcARs1;
          w_ctrl.alu_src_b = SrcBImm;
          w_ctrl.alu_op    = AluOpFunct;
        end
        StAluWb:    w_ctrl.reg_write = 1'b1;
        StBranch: begin
          w_ctrl.alu_src_a = SrcARs1;
          w_ctrl.alu_op    = AluOpSub;
          w_ctrl.pc_write  = w_br_taken;
          w_ctrl.illegal   = !w_br_legal;
        end
        StJal: begin
          w_ctrl.alu_src_a = SrcAOldPc;
          w_ctrl.alu_src_b = SrcBFour;
          w_ctrl.pc_write  = 1'b1;
        end
        default: w_ctrl = '0;
      endcase
    end
  end

  // Immediate format follows the opcode regardless of state.
  always_comb begin
    case (w_opcode)
      OpStore:  bus.imm_src = ImmS;
      OpBranch: bus.imm_src = ImmB;
      OpJal:    bus.imm_src = ImmJ;
      default:  bus.imm_src = ImmI;
    endcase
  end

  control_alu_decoder u_alu_decoder (
    .i_opcode      (w_opcode),
    .i_funct7_5    (w_funct7_5),
    .i_funct3      (w_funct3),
    .i_alu_op      (w_ctrl.alu_op),
    .o_alu_control (bus.alu_control)
  );

  assign bus.pc_write      = w_ctrl.pc_write;
  assign bus.ir_write      = w_ctrl.ir_write;
  assign bus.mem_write     = w_ctrl.mem_write;
  assign bus.reg_write     = w_ctrl.reg_write;
  assign bus.adr_src       = w_ctrl.adr_src;
  assign bus.alu_src_a     = w_ctrl.alu_src_a;
  assign bus.alu_src_b     = w_ctrl.alu_src_b;
  assign bus.result_src    = w_ctrl.result_src;
  assign bus.illegal_instr = w_ctrl.illegal;
  assign bus.state_o       = r_state;

endmodule

// File: tb/tb_control_multicycle.sv
// Scoreboard bench for control_multicycle: each cycle pushes the expected
// output record and pops it against the DUT outputs mid-cycle.
module tb_control_multicycle;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       mw;
    logic       rw;
    logic       adr;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] rs;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  control_multicycle_if #(.INSTR_WIDTH(32)) bus ();

  control_multicycle #(.INSTR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2:0] funct_alu(input logic [6:0] op, input logic f7, input logic [2:0] f3);
    case (f3)
      3'b000:  return (f7 && op[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for a given (expected) state and the current inputs.
  function automatic exp_t model(input logic [3:0] st, input logic [31:0] ins, input logic z,
                                 input logic lt, input logic ltu, input logic mr,
                                 input logic rst);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic       ok;
    logic       tk;
    op = ins[6:0];
    f3 = ins[14:12];
    e = '0;
    e.st = st;
    case (op)
      7'b0100011: e.imm = 2'b01;
      7'b1100011: e.imm = 2'b10;
      7'b1101111: e.imm = 2'b11;
      default:    e.imm = 2'b00;
    endcase
    if (!rst) begin
      e.b  = 2'b10;
      e.rs = 2'b10;
      return e;
    end
    case (st)
      4'd0: begin e.b = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1: begin
        e.a = 2'b01; e.b = 2'b01;
        e.ill = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                  op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111);
      end
      4'd2: begin e.a = 2'b10; e.b = 2'b01; end
      4'd3: e.adr = 1'b1;
      4'd4: begin e.rs = 2'b01; e.rw = 1'b1; end
      4'd5: begin e.adr = 1'b1; e.mw = 1'b1; end
      4'd6: begin e.a = 2'b10; e.b = 2'b00; e.alu = funct_alu(op, ins[30], f3); end
      4'd7: begin e.a = 2'b10; e.b = 2'b01; e.alu = funct_alu(op, ins[30], f3); end
      4'd8: e.rw = 1'b1;
      4'd9: begin
        e.a = 2'b10; e.alu = 3'b001;
        ok = 1'b1; tk = 1'b0;
        case (f3)
          3'b000: tk = z;
          3'b001: tk = !z;
`ifdef CONTROL_FULL_BRANCH_EN
          3'b100: tk = lt;
          3'b101: tk = !lt;
          3'b110: tk = ltu;
          3'b111: tk = !ltu;
`endif
          default: ok = 1'b0;
        endcase
        e.pcw = ok & tk;
        e.ill = !ok;
      end
      4'd10: begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
      default: e = e;
    endcase
    return e;
  endfunction

  // One cycle: called at a falling edge, compares 2 time units later.
  task automatic cyc(input string name, input logic [3:0] st, input logic mr);
    exp_t e;
    bus.mem_ready = mr;
    sb.push_back(model(st, bus.instr, bus.zero, bus.lt, bus.ltu, mr, rst_n));
    #2;
    e = sb.pop_front();
    check_eq({name, ".state"},  {28'd0, bus.state_o},     {28'd0, e.st});
    check_eq({name, ".pcw"},    {31'd0, bus.pc_write},    {31'd0, e.pcw});
    check_eq({name, ".irw"},    {31'd0, bus.ir_write},    {31'd0, e.irw});
    check_eq({name, ".memw"},   {31'd0, bus.mem_write},   {31'd0, e.mw});
    check_eq({name, ".regw"},   {31'd0, bus.reg_write},   {31'd0, e.rw});
    check_eq({name, ".adr"},    {31'd0, bus.adr_src},     {31'd0, e.adr});
    check_eq({name, ".srca"},   {30'd0, bus.alu_src_a},   {30'd0, e.a});
    check_eq({name, ".srcb"},   {30'd0, bus.alu_src_b},   {30'd0, e.b});
    check_eq({name, ".res"},    {30'd0, bus.result_src},  {30'd0, e.rs});
    check_eq({name, ".imm"},    {30'd0, bus.imm_src},     {30'd0, e.imm});
    check_eq({name, ".alu"},    {29'd0, bus.alu_control}, {29'd0, e.alu});
    check_eq({name, ".ill"},    {31'd0, bus.illegal_instr}, {31'd0, e.ill});
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] ins, input logic z, input logic lt, input logic ltu);
    bus.instr = ins;
    bus.zero  = z;
    bus.lt    = lt;
    bus.ltu   = ltu;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    set_in(32'h0040_2083, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    cyc("reset", 4'd0, 1'b1);
    rst_n = 1'b1;

    // lw x1,4(x0)
    cyc("lw", 4'd0, 1'b1); cyc("lw", 4'd1, 1'b1); cyc("lw", 4'd2, 1'b1);
    cyc("lw", 4'd3, 1'b1); cyc("lw", 4'd4, 1'b1);

    // sw x2,8(x0) with fetch stall and 3-cycle write stall
    set_in(32'h0020_2423, 1'b0, 1'b0, 1'b0);
    cyc("sw_f", 4'd0, 1'b0); cyc("sw_f", 4'd0, 1'b0); cyc("sw_f", 4'd0, 1'b1);
    cyc("sw", 4'd1, 1'b1); cyc("sw", 4'd2, 1'b1);
    for (int i = 0; i < 3; i++) cyc("sw_w", 4'd5, 1'b0);
    cyc("sw_w", 4'd5, 1'b1);

    // R-type sub / and, I-type addi (bit30 set) / slti
    set_in(32'h4020_81B3, 1'b0, 1'b0, 1'b0);
    cyc("sub", 4'd0, 1'b1); cyc("sub", 4'd1, 1'b1); cyc("sub", 4'd6, 1'b1); cyc("sub", 4'd8, 1'b1);
    set_in(32'h0020_F1B3, 1'b0, 1'b0, 1'b0);
    cyc("and", 4'd0, 1'b1); cyc("and", 4'd1, 1'b1); cyc("and", 4'd6, 1'b1); cyc("and", 4'd8, 1'b1);
    set_in(32'h4000_0093, 1'b0, 1'b0, 1'b0);
    cyc("addi", 4'd0, 1'b1); cyc("addi", 4'd1, 1'b1); cyc("addi", 4'd7, 1'b1);
    cyc("addi", 4'd8, 1'b1);
    set_in(32'h0050_2093, 1'b0, 1'b0, 1'b0);
    cyc("slti", 4'd0, 1'b1); cyc("slti", 4'd1, 1'b1); cyc("slti", 4'd7, 1'b1);
    cyc("slti", 4'd8, 1'b1);

    // Branches: beq/bne with zero=1, blt lt=1, bgeu ltu=0, funct3 010
    set_in(32'h0000_0063, 1'b1, 1'b0, 1'b0);
    cyc("beq", 4'd0, 1'b1); cyc("beq", 4'd1, 1'b1); cyc("beq", 4'd9, 1'b1);
    set_in(32'h0000_1063, 1'b1, 1'b0, 1'b0);
    cyc("bne", 4'd0, 1'b1); cyc("bne", 4'd1, 1'b1); cyc("bne", 4'd9, 1'b1);
    set_in(32'h0000_4063, 1'b0, 1'b1, 1'b0);
    cyc("blt", 4'd0, 1'b1); cyc("blt", 4'd1, 1'b1); cyc("blt", 4'd9, 1'b1);
    set_in(32'h0000_7063, 1'b0, 1'b0, 1'b0);
    cyc("bgeu", 4'd0, 1'b1); cyc("bgeu", 4'd1, 1'b1); cyc("bgeu", 4'd9, 1'b1);
    set_in(32'h0000_2063, 1'b1, 1'b0, 1'b0);
    cyc("br010", 4'd0, 1'b1); cyc("br010", 4'd1, 1'b1); cyc("br010", 4'd9, 1'b1);

    // jal x1,0
    set_in(32'h0000_00EF, 1'b0, 1'b0, 1'b0);
    cyc("jal", 4'd0, 1'b1); cyc("jal", 4'd1, 1'b1); cyc("jal", 4'd10, 1'b1);
    cyc("jal", 4'd8, 1'b1);

    // Illegal opcode 0000000 returns to FETCH
    set_in(32'h0000_0000, 1'b0, 1'b0, 1'b0);
    cyc("ill", 4'd0, 1'b1); cyc("ill", 4'd1, 1'b1);

    // lw abandoned by reset during MEMWB
    set_in(32'h0040_2083, 1'b0, 1'b0, 1'b0);
    cyc("lw_rst", 4'd0, 1'b1); cyc("lw_rst", 4'd1, 1'b1); cyc("lw_rst", 4'd2, 1'b1);
    cyc("lw_rst", 4'd3, 1'b1);
    rst_n = 1'b0;
    cyc("lw_rst_wb", 4'd4, 1'b1);
    rst_n = 1'b1;
    cyc("after_rst", 4'd0, 1'b1);
    cyc("after_rst", 4'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
